// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer queue: FSM state encoding and default byte width.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    GAP   = 2'b11
  } xferState_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wrPtr;
  logic [AW:0]       rdPtr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              doPush;
  logic              doPop;

  // Extra pointer MSB separates "full" from "empty" when the index bits match.
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = empty ? '0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; head is masked to zero while empty,
  // so stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Queues bytes for an SPI slave stage, hands them out one transfer at a time with an
// enforced idle gap, and collects the bytes received back into an RX FIFO.
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx_full,
  output logic              send_start,
  output logic [DATA_W-1:0] send_data,
  input  logic              xfer_done,
  input  logic [DATA_W-1:0] recv_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rx_empty,
  output logic              busy,
  output logic              rx_overflow
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  xferState_e        state;
  logic [3:0]        gapCnt;
  logic              txEmpty;
  logic [DATA_W-1:0] txHead;
  logic              rxFull;
  logic              rxPush;

  assign rxPush = (state == START) && xfer_done;
  assign busy   = (state != IDLE) || !txEmpty;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) txFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .pushData (wr_data),
    .pop      (state == IDLE),
    .full     (tx_full),
    .empty    (txEmpty),
    .head     (txHead)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rxFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rxPush),
    .pushData (recv_data),
    .pop      (rd_en),
    .full     (rxFull),
    .empty    (rx_empty),
    .head     (rd_data)
  );

  // A full RX FIFO still takes the byte when a read frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                                rx_overflow <= 1'b0;
    else if (rxPush && rxFull && !rd_en)    rx_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      send_start <= 1'b0;
      send_data  <= '0;
      gapCnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!txEmpty) begin
            send_data  <= txHead;
            send_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (xfer_done) begin
            send_start <= 1'b0;
            gapCnt     <= GAP_LOAD;
            state      <= GAP;
          end
        end
        GAP: begin
          if (gapCnt == 4'd0) state  <= IDLE;
          else                gapCnt <= gapCnt - 4'd1;
        end
        default: begin
          send_start <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Bench for spi_xfer_queue: directed scenarios plus random traffic against a queue-based model.
module tb_spi_xfer_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_full;
  logic          send_start;
  logic [DW-1:0] send_data;
  logic          xfer_done = 1'b0;
  logic [DW-1:0] recv_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rx_empty;
  logic          busy;
  logic          rx_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queues plus the time of the last transfer end.
  bit            mStart;
  logic [DW-1:0] mData;
  logic [DW-1:0] mTx[$];
  logic [DW-1:0] mRx[$];
  bit            mOvf;
  int            cyc = 0;
  int            lastFall = -100;

  spi_xfer_queue #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_full     (tx_full),
    .send_start  (send_start),
    .send_data   (send_data),
    .xfer_done   (xfer_done),
    .recv_data   (recv_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rx_empty    (rx_empty),
    .busy        (busy),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;

  // Advance the model with the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit popTx;
    bit gotByte;
    if (rst) begin
      mStart = 0; mData = '0; mTx.delete(); mRx.delete(); mOvf = 0; lastFall = -100;
    end else begin
      popTx   = !mStart && (mTx.size() > 0) && (cyc - lastFall >= GAP + 1);
      gotByte = mStart && xfer_done;
      if (gotByte) begin mStart = 0; lastFall = cyc; end
      if (rd_en && mRx.size() > 0) void'(mRx.pop_front());
      if (gotByte) begin
        if (mRx.size() < DEPTH) mRx.push_back(recv_data);
        else                    mOvf = 1;
      end
      if (popTx) begin mData = mTx.pop_front(); mStart = 1; end
      if (wr_en && mTx.size() < DEPTH) mTx.push_back(wr_data);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input logic [DW-1:0] s, input logic [DW-1:0] r);
    wr_en = 1; wr_data = s; tick(); wr_en = 0;
    for (int t = 0; t < 20 && !send_start; t++) tick();
    checks++;
    if (send_start !== 1'b1 || send_data !== s) begin
      errors++;
      $display("FAIL xfer_start start=%0b data=%h want start=1 data=%h", send_start, send_data, s);
    end
    tick();
    xfer_done = 1; recv_data = r; tick(); xfer_done = 0;
    repeat (GAP + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 1; wr_data = 8'hFF; xfer_done = 1; rd_en = 1;
    tick();
    tick();
    wr_en = 0; xfer_done = 0; rd_en = 0;
    checks += 7;
    if (send_start !== 1'b0) begin errors++; $display("FAIL reset_send_start got %b want 0", send_start); end
    if (send_data !== 8'h00) begin errors++; $display("FAIL reset_send_data got %h want 00", send_data); end
    if (tx_full !== 1'b0)    begin errors++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    if (rx_empty !== 1'b1)   begin errors++; $display("FAIL reset_rx_empty got %b want 1", rx_empty); end
    if (rd_data !== 8'h00)   begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", rx_overflow); end
    rst = 0;
  endtask

  task automatic test_single();
    wr_en = 1; wr_data = 8'hA5; tick(); wr_en = 0;
    checks++;
    if (send_start !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", send_start); end
    tick();
    checks++;
    if (send_start !== 1'b1) begin errors++; $display("FAIL latency_two got %b want 1", send_start); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (send_start !== 1'b1 || send_data !== 8'hA5) begin
        errors++; $display("FAIL single_hold cyc %0d start=%b data=%h want 1/a5", i, send_start, send_data);
      end
      if (i < 4) tick();
    end
    xfer_done = 1; recv_data = 8'h3C; tick(); xfer_done = 0;
    checks += 3;
    if (send_start !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", send_start); end
    if (rx_empty !== 1'b0)   begin errors++; $display("FAIL single_rx_empty got %b want 0", rx_empty); end
    if (rd_data !== 8'h3C)   begin errors++; $display("FAIL single_rd_data got %h want 3c", rd_data); end
    rd_en = 1; tick(); rd_en = 0;
    repeat (GAP) tick();
    checks += 2;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", rx_empty); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  // Fill TX while a transfer is in flight, then run 5 transfers with no reads.
  task automatic test_fill_overflow();
    int  low;
    bit  sawStart;
    wr_en = 1; wr_data = 8'hEE; tick(); wr_en = 0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1; wr_data = 8'(i); tick(); wr_en = 0;
      if (i >= 4) begin
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL fill_tx_full push %0d got %b want 1", i, tx_full); end
      end
    end
    recv_data = 8'h10; xfer_done = 1; tick(); xfer_done = 0;
    for (int b = 1; b <= 4; b++) begin
      xfer_done = (b == 2); recv_data = 8'hEE;
      low = 1;
      for (int t = 0; t < 20; t++) begin
        tick();
        if (send_start) break;
        low++;
      end
      xfer_done = 0;
      checks += 2;
      if (low !== GAP + 1) begin errors++; $display("FAIL gap_len byte %0d got %0d want %0d", b, low, GAP + 1); end
      if (send_data !== 8'(b)) begin errors++; $display("FAIL order byte %0d got %h want %h", b, send_data, 8'(b)); end
      repeat ($urandom_range(1, 3)) tick();
      recv_data = 8'(8'h10 + b); xfer_done = 1; tick(); xfer_done = 0;
    end
    sawStart = 0;
    repeat (10) begin tick(); if (send_start) sawStart = 1; end
    checks += 2;
    if (sawStart !== 1'b0)   begin errors++; $display("FAIL dropped_byte_sent got %b want 0", sawStart); end
    if (rx_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b want 1", rx_overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL rx_order %0d got %h want %h", i, rd_data, 8'(8'h10 + i)); end
      rd_en = 1; tick(); rd_en = 0;
    end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_drained got %b want 1", rx_empty); end
  endtask

  task automatic test_abort();
    bit sawStart;
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'hB0 + i); tick();
    end
    wr_en = 0;
    checks++;
    if (send_start !== 1'b1) begin errors++; $display("FAIL abort_setup got %b want 1", send_start); end
    rst = 1; xfer_done = 1; recv_data = 8'h77; tick(); rst = 0; xfer_done = 0;
    checks += 4;
    if (send_start !== 1'b0) begin errors++; $display("FAIL abort_send_start got %b want 0", send_start); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (tx_full !== 1'b0)    begin errors++; $display("FAIL abort_tx_full got %b want 0", tx_full); end
    if (rx_empty !== 1'b1)   begin errors++; $display("FAIL abort_rx_empty got %b want 1", rx_empty); end
    sawStart = 0;
    repeat (8) begin tick(); if (send_start) sawStart = 1; end
    checks++;
    if (sawStart !== 1'b0) begin errors++; $display("FAIL abort_restart got %b want 0", sawStart); end
  endtask

  task automatic test_full_rw();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) run_xfer(8'(8'h60 + i), 8'(8'h40 + i));
    wr_en = 1; wr_data = 8'h55; tick(); wr_en = 0;
    for (int t = 0; t < 20 && !send_start; t++) tick();
    xfer_done = 1; recv_data = 8'h44; rd_en = 1; tick(); xfer_done = 0; rd_en = 0;
    checks += 2;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got %b want 0", rx_overflow); end
    if (rx_empty !== 1'b0)    begin errors++; $display("FAIL fullrw_empty got %b want 0", rx_empty); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_data !== 8'(8'h40 + i)) begin errors++; $display("FAIL fullrw_order %0d got %h want %h", i, rd_data, 8'(8'h40 + i)); end
      rd_en = 1; tick(); rd_en = 0;
    end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL fullrw_drained got %b want 1", rx_empty); end
  endtask

  task automatic test_random();
    logic [DW-1:0] expRd;
    bit            expBusy;
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 1500; n++) begin
      wr_en     = ($urandom_range(0, 9) < 4);
      wr_data   = 8'($urandom);
      rd_en     = ($urandom_range(0, 9) < 3);
      recv_data = 8'($urandom);
      xfer_done = send_start ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      tick();
      expRd   = (mRx.size() > 0) ? mRx[0] : '0;
      expBusy = mStart || ((cyc - 1 - lastFall) < GAP) || (mTx.size() > 0);
      checks += 7;
      if (send_start !== mStart) begin errors++; $display("FAIL rnd_start cyc %0d got %b want %b", cyc, send_start, mStart); end
      if (send_data !== mData)   begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, send_data, mData); end
      if (tx_full !== (mTx.size() == DEPTH)) begin errors++; $display("FAIL rnd_tx_full cyc %0d got %b want %b", cyc, tx_full, mTx.size() == DEPTH); end
      if (rx_empty !== (mRx.size() == 0))    begin errors++; $display("FAIL rnd_rx_empty cyc %0d got %b want %b", cyc, rx_empty, mRx.size() == 0); end
      if (rd_data !== expRd)     begin errors++; $display("FAIL rnd_rd_data cyc %0d got %h want %h", cyc, rd_data, expRd); end
      if (busy !== expBusy)      begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, expBusy); end
      if (rx_overflow !== mOvf)  begin errors++; $display("FAIL rnd_overflow cyc %0d got %b want %b", cyc, rx_overflow, mOvf); end
    end
    wr_en = 0; rd_en = 0; xfer_done = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_abort();
    test_full_rw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
